interrupt_controller: RTL



---
 rtl/interrupt_controller.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//
// Collects up to 31 peripheral interrupt lines into one CPU interrupt request.
// Each source has a pending bit, an enable bit, a mode bit (level or rising
// edge) and an in-service bit. Software claims the highest-priority source
// with a read of CLAIM and releases it with a write of its ID to COMPLETE.
// The lowest source index has the highest priority. Source k has ID k+1.
//
// Register map (word index):
//   0 PENDING   read, write-1-to-clear
//   1 ENABLE    read/write
//   2 MODE      read/write, 1 = level, 0 = rising edge
//   3 CLAIM     read only (the read itself claims)
//   4 COMPLETE  write only, reads 0
//   5 INSERVICE read only
//   6 DEVICEID  read only
//   7 NSOURCES  read only
//
// Build option:
//   INTERRUPT_CONTROLLER_SYNC_EN - when defined, every interrupt line passes
//   through a two-flop synchronizer ahead of the edge/level logic, which adds
//   two cycles to every interrupt latency. When undefined, the lines must
//   already be synchronous to i_clock.
// -----------------------------------------------------------------------------
module interrupt_controller #(
  parameter int          NSOURCES = 8,
  parameter logic [31:0] DEVICEID = 32'd0
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_request,
  input  logic                i_rw,
  input  logic [2:0]          i_address,
  input  logic [31:0]         i_wdata,
  output logic [31:0]         o_rdata,
  output logic                o_ready,
  input  logic [NSOURCES-1:0] i_interrupt,
  output logic                o_interrupt
);

  // IDs run 1..31, so five bits always hold one.
  localparam int IDW = 5;

  typedef enum logic [2:0] {
    ADDR_PENDING   = 3'd0,
    ADDR_ENABLE    = 3'd1,
    ADDR_MODE      = 3'd2,
    ADDR_CLAIM     = 3'd3,
    ADDR_COMPLETE  = 3'd4,
    ADDR_INSERVICE = 3'd5,
    ADDR_DEVICEID  = 3'd6,
    ADDR_NSOURCES  = 3'd7
  } reg_addr_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                r_req_prev;
  logic                r_ready;
  logic [31:0]         r_rdata;
  logic                r_irq;

  logic [NSOURCES-1:0] r_pending;
  logic [NSOURCES-1:0] r_enable;
  logic [NSOURCES-1:0] r_mode;
  logic [NSOURCES-1:0] r_inservice;
  logic [NSOURCES-1:0] r_sample;   // registered line value seen by edge/level logic
  logic [NSOURCES-1:0] r_history;  // previous r_sample, for rising-edge detection

  // ---------------------------------------------------------------------------
  // Combinational nets
  // ---------------------------------------------------------------------------
  logic [NSOURCES-1:0] w_line;
  logic                w_accept;
  logic                w_rd;
  logic                w_wr;
  logic                w_claim;
  logic                w_complete;
  logic                w_w1c_en;
  logic [NSOURCES-1:0] w_qual;
  logic [NSOURCES-1:0] w_claim_sel;
  logic [IDW-1:0]      w_claim_id;
  logic [NSOURCES-1:0] w_claim_hot;
  logic [NSOURCES-1:0] w_complete_hot;
  logic [NSOURCES-1:0] w_w1c;
  logic [NSOURCES-1:0] w_edge_set;
  logic [NSOURCES-1:0] w_level_set;
  logic [NSOURCES-1:0] w_set;
  logic [NSOURCES-1:0] w_pending_next;
  logic [NSOURCES-1:0] w_inservice_next;
  logic [31:0]         w_rdata;

  // ---------------------------------------------------------------------------
  // Optional input synchronizer
  // ---------------------------------------------------------------------------
`ifdef INTERRUPT_CONTROLLER_SYNC_EN
  logic [NSOURCES-1:0] r_sync1;
  logic [NSOURCES-1:0] r_sync2;

  // Two-flop synchronizer bringing asynchronous lines into the i_clock domain.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_interrupt;
      r_sync2 <= r_sync1;
    end
  end

  assign w_line = r_sync2;
`else
  assign w_line = i_interrupt;
`endif

  // ---------------------------------------------------------------------------
  // Bus decode: one access per rising edge of i_request
  // ---------------------------------------------------------------------------
  assign w_accept   = i_request & ~r_req_prev;
  assign w_rd       = w_accept & ~i_rw;
  assign w_wr       = w_accept &  i_rw;
  assign w_claim    = w_rd && (i_address == ADDR_CLAIM);
  assign w_complete = w_wr && (i_address == ADDR_COMPLETE);
  assign w_w1c_en   = w_wr && (i_address == ADDR_PENDING);

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign w_qual = r_pending & r_enable & ~r_inservice;

  // Fixed-priority encoder: scanning downwards lets the lowest index win.
  // NOTE: every always_comb output gets a default before any branch, otherwise
  // a path that skips the assignment would infer a latch.
  always_comb begin
    w_claim_id  = '0;
    w_claim_sel = '0;
    for (int k = NSOURCES - 1; k >= 0; k--) begin
      if (w_qual[k]) begin
        w_claim_id     = IDW'(k + 1);
        w_claim_sel    = '0;
        w_claim_sel[k] = 1'b1;
      end
    end
  end

  assign w_claim_hot = w_claim ? w_claim_sel : '0;

  // Complete decode: only IDs 1..NSOURCES match a source; anything else is a no-op.
  always_comb begin
    w_complete_hot = '0;
    for (int k = 0; k < NSOURCES; k++) begin
      w_complete_hot[k] = w_complete && (i_wdata == 32'(k + 1));
    end
  end

  assign w_w1c = w_w1c_en ? i_wdata[NSOURCES-1:0] : '0;

  // ---------------------------------------------------------------------------
  // Pending / in-service next state
  // ---------------------------------------------------------------------------
  assign w_edge_set  = r_sample & ~r_history;
  // A source being claimed on this edge counts as in service, so a held level
  // line does not immediately re-pend the interrupt it is being claimed for.
  assign w_level_set = r_sample & ~(r_inservice | w_claim_hot);
  assign w_set       = (r_mode & w_level_set) | (~r_mode & w_edge_set);

  // Set has priority over claim-clear and write-1-to-clear.
  assign w_pending_next   = (r_pending & ~(w_claim_hot | w_w1c)) | w_set;
  assign w_inservice_next = (r_inservice | w_claim_hot) & ~w_complete_hot;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  // Selects the read value for the addressed register, zero-extended to 32 bits.
  always_comb begin
    w_rdata = '0;
    case (i_address)
      ADDR_PENDING:   w_rdata = 32'(r_pending);
      ADDR_ENABLE:    w_rdata = 32'(r_enable);
      ADDR_MODE:      w_rdata = 32'(r_mode);
      ADDR_CLAIM:     w_rdata = 32'(w_claim_id);
      ADDR_COMPLETE:  w_rdata = '0;
      ADDR_INSERVICE: w_rdata = 32'(r_inservice);
      ADDR_DEVICEID:  w_rdata = DEVICEID;
      ADDR_NSOURCES:  w_rdata = 32'(NSOURCES);
      default:        w_rdata = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------
  // Bus handshake: accept on request rise, hold ready until request drops.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order or block ordering.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      // Previous-request resets high so a request still asserted across reset
      // must drop for one sampled clock before it can start a new access.
      r_req_prev <= 1'b1;
      r_ready    <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_req_prev <= i_request;
      if (w_accept) begin
        r_ready <= 1'b1;
        if (!i_rw) begin
          r_rdata <= w_rdata;
        end
      end else if (!i_request) begin
        r_ready <= 1'b0;
      end
    end
  end

  // Software-configured enable and mode masks.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_enable <= '0;
      r_mode   <= '0;
    end else if (w_wr) begin
      if (i_address == ADDR_ENABLE) begin
        r_enable <= i_wdata[NSOURCES-1:0];
      end
      if (i_address == ADDR_MODE) begin
        r_mode <= i_wdata[NSOURCES-1:0];
      end
    end
  end

  // Line sampling, pending/in-service tracking and the registered CPU request.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sample    <= '0;
      r_history   <= '0;
      r_pending   <= '0;
      r_inservice <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_sample    <= w_line;
      r_history   <= r_sample;
      r_pending   <= w_pending_next;
      r_inservice <= w_inservice_next;
      r_irq       <= |w_qual;
    end
  end

  assign o_rdata     = r_rdata;
  assign o_ready     = r_ready;
  assign o_interrupt = r_irq;

endmodule
